// File: rtl/pair_serializer.sv
// Pair serializer: FIFO-buffered 16-bit char pairs out as a byte stream.
// Optional newline byte after each line end: PAIR_SERIALIZER_NEWLINE_EN.
module pair_serializer #(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  PAD_CHAR = 8'h20,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_pair,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_eol,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LHS,
        RHS
`ifdef PAIR_SERIALIZER_NEWLINE_EN
        , NL
`endif
    } state_t;

    state_t        state, state_n;
    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [16:0]   head;
    logic          head_pad;
    logic [7:0]    rhs_q, rhs_n;
    logic          last_q, last_n;
    logic          valid_n, eol_n;
    logic [7:0]    char_n;

    assign in_ready = (count < FULL);
    assign push     = in_valid & in_ready;
    assign busy     = (count != '0) | (state != IDLE);
    assign head     = mem[rd_ptr];
    assign head_pad = (head[15:0] == {PAD_CHAR, PAD_CHAR}) & ~head[16];

    always_comb begin
        state_n = state;
        valid_n = out_valid;
        char_n  = out_char;
        eol_n   = out_eol;
        rhs_n   = rhs_q;
        last_n  = last_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    // all-padding words without a line end vanish here
                    if (!head_pad) begin
                        char_n  = head[15:8];
                        valid_n = 1'b1;
                        eol_n   = 1'b0;
                        rhs_n   = head[7:0];
                        last_n  = head[16];
                        state_n = LHS;
                    end
                end
            end
            LHS: begin
                if (out_ready) begin
                    char_n  = rhs_q;
`ifdef PAIR_SERIALIZER_NEWLINE_EN
                    eol_n   = 1'b0;
`else
                    eol_n   = last_q;
`endif
                    state_n = RHS;
                end
            end
            RHS: begin
                if (out_ready) begin
`ifdef PAIR_SERIALIZER_NEWLINE_EN
                    if (last_q) begin
                        char_n  = 8'h0A;
                        eol_n   = 1'b1;
                        state_n = NL;
                    end else
`endif
                    begin
                        valid_n = 1'b0;
                        eol_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
`ifdef PAIR_SERIALIZER_NEWLINE_EN
            NL: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    eol_n   = 1'b0;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_last, in_pair};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_char   <= 8'h00;
            out_eol    <= 1'b0;
            rhs_q      <= 8'h00;
            last_q     <= 1'b0;
            byte_count <= '0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            out_char  <= char_n;
            out_eol   <= eol_n;
            rhs_q     <= rhs_n;
            last_q    <= last_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
            if (out_valid && out_ready)
                byte_count <= byte_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pair_serializer.sv
// Scoreboard bench for pair_serializer; adapts to PAIR_SERIALIZER_NEWLINE_EN.
module tb_pair_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pair = 16'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_char;
    logic        out_eol;
    logic        busy;
    logic [3:0]  byte_count;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb [$];

`ifdef PAIR_SERIALIZER_NEWLINE_EN
    localparam int NLB = 1;
`else
    localparam int NLB = 0;
`endif

    pair_serializer #(.DEPTH(4), .PAD_CHAR(8'h20), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pair(in_pair), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_eol(out_eol),
        .busy(busy), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is matched to the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL byte: got %0h/%0b expected none",
                         out_char, out_eol);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({out_eol, out_char} !== e) begin
                    errors++;
                    $display("FAIL byte: got %0h/%0b expected %0h/%0b",
                             out_char, out_eol, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic expect_word(input logic [15:0] p, input logic l);
        if (p == 16'h2020 && !l) return;
        sb.push_back({1'b0, p[15:8]});
        if (NLB == 1) begin
            sb.push_back({1'b0, p[7:0]});
            if (l) sb.push_back({1'b1, 8'h0A});
        end else begin
            sb.push_back({l, p[7:0]});
        end
    endtask

    task automatic push(input logic [15:0] p, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_pair  = p;
        in_last  = l;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("push_timeout", 1, 0);
        expect_word(p, l);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((busy || out_valid) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_timeout"}, (busy || out_valid), 0);
        @(negedge clk); @(posedge clk); #1;
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_char", out_char, 8'h00);
        check("rst_eol", out_eol, 0);
        check("rst_busy", busy, 0);
        check("rst_count", byte_count, 0);
        check("rst_ready", in_ready, 1);

        out_ready = 1'b1;
        push(16'h3131, 1'b0);
        push(16'h7320, 1'b1);
        drain("basic");
        check("basic_count", byte_count, 4 + NLB);

        do_reset();
        push(16'h2020, 1'b0);
        push(16'h5E20, 1'b0);
        push(16'h2020, 1'b1);
        drain("pad");
        check("pad_count", byte_count, 4 + NLB);

        do_reset();
        push(16'h4142, 1'b0);
        check("lat_n1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_char", out_char, 8'h41);
        drain("lat");

        do_reset();
        out_ready = 1'b0;
        push(16'h3132, 1'b0);
        push(16'h3334, 1'b0);
        push(16'h3536, 1'b0);
        push(16'h3738, 1'b0);
        push(16'h3930, 1'b1);
        check("full_ready", in_ready, 0);
        check("full_valid", out_valid, 1);
        check("full_char", out_char, 8'h31);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_char", out_char, 8'h31);
        check("hold_ready", in_ready, 0);
        out_ready = 1'b1;
        drain("full");
        check("full_count", byte_count, 10 + NLB);

        do_reset();
        out_ready = 1'b0;
        push(16'h4142, 1'b0);
        push(16'h4344, 1'b0);
        push(16'h4546, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_valid_pre", out_valid, 1);
        sb.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_count", byte_count, 0);
        check("mid_ready", in_ready, 1);
        out_ready = 1'b1;
        push(16'h5859, 1'b1);
        drain("mid");
        check("mid_after_count", byte_count, 2 + NLB);

        do_reset();
        for (int i = 0; i < 9; i++)
            push(16'h6162 + 16'(i), 1'b0);
        drain("wrap");
        check("wrap_count", byte_count, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
